// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL manager with on-chip word memory.
// 2-entry request buffer, in-order single-outstanding access FSM.
module tl_ul_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SOURCE_W    = 4,
  parameter int DEPTH_WORDS = 4096,
  parameter int BASE        = 0,
  parameter int MEM_LAT     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef struct packed {
    logic [2:0]          op;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] src;
    logic [ADDR_W-1:0]   addr;
    logic [3:0]          mask;
    logic [DATA_W-1:0]   data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            r_state;
  req_t              r_q [2];
  req_t              r_cur;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  logic [LW-1:0]     r_lat;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  req_t              w_req;
  req_t              w_head;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_off;
  logic              w_inrng;
  logic              w_misal;
  logic [3:0]        w_imp;
  logic              w_get;
  logic              w_pfull;
  logic              w_ppart;
  logic              w_bad_mask;
  logic              w_deny;
  logic [3:0]        w_wmask;
  logic [IW-1:0]     w_idx;
  logic              w_fire;
  logic              w_wr;

  assign a_ready = !reset_i && (r_cnt != 2'd2);
  assign w_push  = a_valid && a_ready;
  assign w_pop   = (r_cnt != 2'd0) &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_RESP) && d_ready));

  assign w_req = '{op: a_opcode, size: a_size, src: a_source,
                   addr: a_address, mask: a_mask, data: a_data};
  assign w_head = r_q[r_rp];

  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wp] <= w_req;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // Request classification on the in-flight request
  assign w_off   = r_cur.addr - ADDR_W'(BASE);
  assign w_inrng = (r_cur.addr >= ADDR_W'(BASE)) &&
                   ({1'b0, w_off} < LIMIT);
  assign w_misal = ((r_cur.size == 2'd1) && r_cur.addr[0]) ||
                   ((r_cur.size == 2'd2) && (r_cur.addr[1:0] != 2'd0));

  always_comb begin
    w_imp = 4'b0000;
    unique case (r_cur.size)
      2'd0: w_imp = 4'b0001 << r_cur.addr[1:0];
      2'd1: w_imp = r_cur.addr[1] ? 4'b1100 : 4'b0011;
      2'd2: w_imp = 4'b1111;
      default: w_imp = 4'b0000;
    endcase
  end

  assign w_get      = (r_cur.op == 3'd4);
  assign w_pfull    = (r_cur.op == 3'd0);
  assign w_ppart    = (r_cur.op == 3'd1);
  assign w_bad_mask = (w_pfull && (r_cur.mask != w_imp)) ||
                      (w_ppart && ((r_cur.mask & ~w_imp) != 4'b0000));
  assign w_deny     = !w_inrng || w_misal || (r_cur.size == 2'd3) ||
                      !(w_get || w_pfull || w_ppart) || w_bad_mask;
  assign w_wmask    = w_ppart ? r_cur.mask : w_imp;
  assign w_idx      = w_off[IW+1:2];
  assign w_fire     = (r_state == S_ACCESS) && (r_lat == '0);
  assign w_wr       = w_fire && !w_deny && !w_get;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= r_cur.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_lat    <= '0;
      r_cur    <= '0;
      d_valid  <= 1'b0;
      d_opcode <= 3'd0;
      d_size   <= 2'd0;
      d_source <= '0;
      d_denied <= 1'b0;
      d_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur   <= w_head;
            r_lat   <= LW'(MEM_LAT - 1);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_lat == '0) begin
            d_valid  <= 1'b1;
            d_opcode <= w_get ? 3'd1 : 3'd0;
            d_size   <= r_cur.size;
            d_source <= r_cur.src;
            d_denied <= w_deny;
            d_data   <= (w_get && !w_deny) ? r_mem[w_idx] : '0;
            r_state  <= S_RESP;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_RESP: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            if (w_pop) begin
              r_cur   <= w_head;
              r_lat   <= LW'(MEM_LAT - 1);
              r_state <= S_ACCESS;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
